// File: rtl/ascon_pack.sv
// Shared Ascon types: the 320-bit permutation state and the end-XOR mode encoding.
package ascon_pack;

    // Five 64-bit words; word 0 occupies bits [63:0], word 4 bits [319:256].
    typedef logic [4:0][63:0] type_state;

    // End-of-permutation XOR selection.
    typedef enum logic [1:0] {
        XOR_BYPASS   = 2'b00,
        XOR_KEY      = 2'b01,
        XOR_DSEP     = 2'b10,
        XOR_KEY_DSEP = 2'b11
    } xor_mode_t;

    // Domain-separation bit position inside state word 4.
    localparam int DSEP_BIT = 0;

    localparam int TAG_W = 128;

endpackage

// File: rtl/ascon_xor_end_stage.sv
// One valid/ready register slice carrying a state word set and its tag-capture flag.
// The slice accepts new data when empty or when its current contents leave this cycle,
// so a full chain of slices streams one item per cycle without bubbles.
module ascon_xor_end_stage
    import ascon_pack::*;
(
    input  logic      clock_i,
    input  logic      resetb_i,
    input  logic      up_valid,
    output logic      up_ready,
    input  type_state up_state,
    input  logic      up_tag,
    output logic      dn_valid,
    input  logic      dn_ready,
    output type_state dn_state,
    output logic      dn_tag
);

    logic      vld;
    logic      advance;
    logic      load;
    type_state state_q;
    logic      tag_q;

    assign advance  = vld & dn_ready;
    assign up_ready = !vld | advance;
    assign load     = up_valid & up_ready;

    // Occupancy: set on load, cleared when the contents leave with nothing replacing them.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            vld <= 1'b0;
        end else if (load) begin
            vld <= 1'b1;
        end else if (advance) begin
            vld <= 1'b0;
        end
    end

    // Payload capture; meaningful only while vld is set, so it carries no reset.
    always_ff @(posedge clock_i) begin
        if (load) begin
            state_q <= up_state;
            tag_q   <= up_tag;
        end
    end

    assign dn_valid = vld;
    assign dn_state = state_q;
    assign dn_tag   = tag_q;

endmodule

// File: rtl/ascon_xor_end_pipe.sv
// Pipelined, flow-controlled Ascon end-of-permutation XOR stage.
// The XOR is applied combinationally on the input side; PIPE_DEPTH register slices
// then only move data. Optional tag capture is enabled by defining ASCON_XOR_END_TAG_EN;
// without it tag_o and tag_valid_o are tied low and tag_capture_i is ignored.
module ascon_xor_end_pipe
    import ascon_pack::*;
#(
    parameter int KEY_W      = 128,
    parameter int PIPE_DEPTH = 1
) (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  type_state        state_i,
    input  logic [KEY_W-1:0] key_i,
    input  xor_mode_t        mode_i,
    input  logic             tag_capture_i,
    output logic             valid_o,
    input  logic             ready_i,
    output type_state        state_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             tag_valid_o
);

    generate
        if (KEY_W != 128 && KEY_W != 160) begin : g_bad_key_w
            $fatal(1, "ascon_xor_end_pipe: KEY_W must be 128 or 160");
        end
        if (PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_depth
            $fatal(1, "ascon_xor_end_pipe: PIPE_DEPTH must be 1..4");
        end
    endgenerate

    // Extra key word for Ascon-80pq; zero for 128-bit keys so the XOR is a no-op there.
    logic [31:0] key_hi;
    generate
        if (KEY_W == 160) begin : g_key160
            assign key_hi = key_i[159:128];
        end else begin : g_key128
            assign key_hi = '0;
        end
    endgenerate

    function automatic type_state end_xor(input type_state s, input logic [127:0] k,
                                          input logic [31:0] khi, input xor_mode_t m);
        type_state r;
        r = s;
        if (m == XOR_KEY || m == XOR_KEY_DSEP) begin
            r[4]       = r[4] ^ k[63:0];
            r[3]       = r[3] ^ k[127:64];
            r[2][31:0] = r[2][31:0] ^ khi;
        end
        if (m == XOR_DSEP || m == XOR_KEY_DSEP) begin
            r[4][DSEP_BIT] = ~r[4][DSEP_BIT];
        end
        return r;
    endfunction

    // Chain links: index k feeds slice k, index PIPE_DEPTH is the output port.
    logic      vld_c [0:PIPE_DEPTH];
    logic      rdy_c [0:PIPE_DEPTH];
    type_state st_c  [0:PIPE_DEPTH];
    logic      tag_c [0:PIPE_DEPTH];

    assign vld_c[0]          = valid_i;
    assign st_c[0]           = end_xor(state_i, key_i[127:0], key_hi, mode_i);
    assign rdy_c[PIPE_DEPTH] = ready_i;
    assign ready_o           = rdy_c[0];
    assign valid_o           = vld_c[PIPE_DEPTH];
    // Stale slice contents never reach the port: the output reads zero while empty.
    assign state_o           = vld_c[PIPE_DEPTH] ? st_c[PIPE_DEPTH] : '0;

    generate
        for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
            ascon_xor_end_stage u_stage (
                .clock_i  (clock_i),
                .resetb_i (resetb_i),
                .up_valid (vld_c[k]),
                .up_ready (rdy_c[k]),
                .up_state (st_c[k]),
                .up_tag   (tag_c[k]),
                .dn_valid (vld_c[k+1]),
                .dn_ready (rdy_c[k+1]),
                .dn_state (st_c[k+1]),
                .dn_tag   (tag_c[k+1])
            );
        end
    endgenerate

`ifdef ASCON_XOR_END_TAG_EN
    logic             out_xfer;
    logic             in_xfer;
    logic [TAG_W-1:0] tag_q;
    logic             tag_vld_q;

    assign tag_c[0] = tag_capture_i;
    assign out_xfer = valid_o & ready_i;
    assign in_xfer  = valid_i & ready_o;

    // Tag register: a flagged output transfer captures; a new flagged input invalidates.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            tag_q     <= '0;
            tag_vld_q <= 1'b0;
        end else if (out_xfer && tag_c[PIPE_DEPTH]) begin
            tag_q     <= {state_o[3], state_o[4]};
            tag_vld_q <= 1'b1;
        end else if (in_xfer && tag_capture_i) begin
            tag_vld_q <= 1'b0;
        end
    end

    assign tag_o       = tag_q;
    assign tag_valid_o = tag_vld_q;
`else
    logic unused_tag;

    assign tag_c[0]    = 1'b0;
    assign unused_tag  = tag_capture_i | tag_c[PIPE_DEPTH];
    assign tag_o       = '0;
    assign tag_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_ascon_xor_end_pipe.sv
// Directed, table-driven bench for ascon_xor_end_pipe (PIPE_DEPTH=2, KEY_W=128).
// Works with or without ASCON_XOR_END_TAG_EN defined.
module tb_ascon_xor_end_pipe;
    import ascon_pack::*;

    localparam int PD = 2;
    localparam int KW = 128;

    logic             clock_i = 1'b0;
    logic             resetb_i;
    logic             valid_i;
    logic             ready_o;
    type_state        state_i;
    logic [KW-1:0]    key_i;
    xor_mode_t        mode_i;
    logic             tag_capture_i;
    logic             valid_o;
    logic             ready_i;
    type_state        state_o;
    logic [TAG_W-1:0] tag_o;
    logic             tag_valid_o;

    ascon_xor_end_pipe #(.KEY_W(KW), .PIPE_DEPTH(PD)) dut (
        .clock_i       (clock_i),
        .resetb_i      (resetb_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .state_i       (state_i),
        .key_i         (key_i),
        .mode_i        (mode_i),
        .tag_capture_i (tag_capture_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .state_o       (state_o),
        .tag_o         (tag_o),
        .tag_valid_o   (tag_valid_o)
    );

    always #5 clock_i = ~clock_i;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        xor_mode_t mode;
        type_state exp;
    } vec_t;

    vec_t      vecs [4];
    type_state s0;
    type_state exp_q [$];

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    initial begin
        int idx;
        int outs;
        int c_first;
        int c_last;
        logic [TAG_W-1:0] exp_tag;
        logic             exp_tv;

        s0[0] = 64'h82bf91294ba5808d;
        s0[1] = 64'hd81eeca694136f8a;
        s0[2] = 64'h0217bc9ebd9fff02;
        s0[3] = 64'h4dd2c87c59c2fb48;
        s0[4] = 64'h4e2b20c3e9eb3044;
        key_i = 128'h691AED630E81901F6CB10AD9CA912F80;

        vecs[0].mode = XOR_BYPASS;
        vecs[0].exp  = s0;
        vecs[1].mode = XOR_KEY;
        vecs[1].exp  = s0;
        vecs[1].exp[3] = 64'h24C8251F57436B57;
        vecs[1].exp[4] = 64'h229A2A1A237A1FC4;
        vecs[2].mode = XOR_DSEP;
        vecs[2].exp  = s0;
        vecs[2].exp[4] = 64'h4e2b20c3e9eb3045;
        vecs[3].mode = XOR_KEY_DSEP;
        vecs[3].exp  = s0;
        vecs[3].exp[3] = 64'h24C8251F57436B57;
        vecs[3].exp[4] = 64'h229A2A1A237A1FC5;

        // Reset state
        resetb_i      = 1'b0;
        valid_i       = 1'b0;
        ready_i       = 1'b1;
        state_i       = s0;
        mode_i        = XOR_BYPASS;
        tag_capture_i = 1'b0;
        repeat (2) @(posedge clock_i);
        #1;
        chk("rst_valid_o", valid_o, 0);
        chk("rst_ready_o", ready_o, 1);
        chk("rst_state_o", state_o, 0);
        chk("rst_tag_o", tag_o, 0);
        chk("rst_tag_valid_o", tag_valid_o, 0);
        @(negedge clock_i);
        resetb_i = 1'b1;
        step();

        // Single transfers per mode, latency PD, one-cycle valid pulse
        for (int i = 0; i < 4; i++) begin
            mode_i  = vecs[i].mode;
            valid_i = 1'b1;
            step();
            valid_i = 1'b0;
            repeat (PD - 1) step();
            chk($sformatf("v%0d_valid", i), valid_o, 1);
            chk($sformatf("v%0d_state", i), state_o, vecs[i].exp);
            step();
            chk($sformatf("v%0d_pulse_end", i), valid_o, 0);
        end

        // Back-to-back inputs with output stalled for 5 cycles
        ready_i = 1'b0;
        idx     = 0;
        mode_i  = vecs[0].mode;
        valid_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (ready_o) begin
                exp_q.push_back(vecs[idx].exp);
                idx++;
            end
            step();
            mode_i = vecs[idx].mode;
        end
        chk("fill_accepts", idx, PD);
        chk("full_ready_o", ready_o, 0);
        chk("full_valid_o", valid_o, 1);
        chk("stall_state_o", state_o, vecs[0].exp);
        ready_i = 1'b1;
        #1;
        chk("push_pop_ready", ready_o, 1);
        outs    = 0;
        c_first = -1;
        c_last  = -1;
        for (int c = 0; c < 20 && outs < 4; c++) begin
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("drain_extra", state_o, 0);
                end else begin
                    chk($sformatf("drain%0d", outs), state_o, exp_q.pop_front());
                end
                if (c_first < 0) c_first = c;
                c_last = c;
                outs++;
            end
            if (valid_i && ready_o) begin
                exp_q.push_back(vecs[idx].exp);
                idx++;
            end
            step();
            if (idx < 4) mode_i = vecs[idx].mode;
            else valid_i = 1'b0;
        end
        chk("drain_count", outs, 4);
        chk("no_bubble", c_last - c_first, 3);

        // Tag capture
        step();
        mode_i        = XOR_KEY;
        tag_capture_i = 1'b1;
        valid_i       = 1'b1;
        step();
        valid_i       = 1'b0;
        tag_capture_i = 1'b0;
        repeat (PD) step();
`ifdef ASCON_XOR_END_TAG_EN
        exp_tag = 128'h24C8251F57436B57_229A2A1A237A1FC4;
        exp_tv  = 1'b1;
`else
        exp_tag = '0;
        exp_tv  = 1'b0;
`endif
        chk("tag_o", tag_o, exp_tag);
        chk("tag_valid_o", tag_valid_o, exp_tv);
        mode_i        = XOR_BYPASS;
        tag_capture_i = 1'b1;
        valid_i       = 1'b1;
        step();
        valid_i       = 1'b0;
        tag_capture_i = 1'b0;
        chk("tag_valid_clear", tag_valid_o, 0);
        repeat (PD) step();
`ifdef ASCON_XOR_END_TAG_EN
        exp_tag = {s0[3], s0[4]};
`endif
        chk("tag_o_second", tag_o, exp_tag);
        chk("tag_valid_second", tag_valid_o, exp_tv);

        // Asynchronous reset with a full pipe
        ready_i = 1'b0;
        mode_i  = XOR_KEY;
        valid_i = 1'b1;
        repeat (PD) step();
        valid_i = 1'b0;
        chk("pre_rst_valid_o", valid_o, 1);
        chk("pre_rst_ready_o", ready_o, 0);
        #2;
        resetb_i = 1'b0;
        #1;
        chk("arst_valid_o", valid_o, 0);
        chk("arst_ready_o", ready_o, 1);
        chk("arst_state_o", state_o, 0);
        chk("arst_tag_o", tag_o, 0);
        chk("arst_tag_valid_o", tag_valid_o, 0);
        ready_i = 1'b1;
        @(negedge clock_i);
        resetb_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("post_rst_idle%0d", c), valid_o, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
